// File: rtl/spi_master_ctrl.sv
// SPI mode-0 frame controller: sequences CS, SCLK and the shifter strobes for one
// MSB-first byte per chip-select assertion, and assembles the received MISO byte.
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_ready,
   output logic       o_load,
   output logic       o_shift,
   output logic       o_sclk,
   output logic       o_cs_n,
   input  logic       i_miso,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_busy
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_HIGH,
      ST_LOW,
      ST_TRAIL,
      ST_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             sclk_q, sclk_d;
   logic             cs_n_q, cs_n_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             phase_end;
   logic             tx_accept;
   logic             tx_byte_unused;

   // The byte itself is captured by the downstream shifter, not here.
   assign tx_byte_unused = ^i_tx_byte;

   assign phase_end = (div_cnt_q == DIV_LAST);
   assign tx_accept = i_tx_valid && (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      if (state_q == ST_IDLE || phase_end) begin
         div_cnt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (tx_accept) begin
               state_d   = ST_LEAD;
               cs_n_d    = 1'b0;
               bit_cnt_d = 3'd0;
            end
         end
         ST_LEAD, ST_LOW: begin
            // MISO is captured on the same edge that raises SCLK.
            if (phase_end) begin
               state_d    = ST_HIGH;
               sclk_d     = 1'b1;
               rx_shift_d = {rx_shift_q[6:0], i_miso};
            end
         end
         ST_HIGH: begin
            if (phase_end) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_TRAIL;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  state_d   = ST_LOW;
               end
            end
         end
         ST_TRAIL: begin
            if (phase_end) begin
               state_d    = ST_GAP;
               cs_n_d     = 1'b1;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= 3'd0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         rx_shift_q <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign o_tx_ready = (state_q == ST_IDLE);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_load     = i_tx_valid && o_tx_ready && !reset;
   // Shift in the last HIGH cycle so MOSI moves with the falling SCLK edge; none after bit 7.
   assign o_shift    = (state_q == ST_HIGH) && phase_end && (bit_cnt_q != 3'd7) && !reset;
   assign o_sclk     = sclk_q;
   assign o_cs_n     = cs_n_q;
   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV 4 and 2), each with a byte shifter
// and a slave model, checked against frame timing and data computed from the SPI rules.
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid [2];
   logic [7:0] tx_byte  [2];
   logic       tx_ready [2];
   logic       load     [2];
   logic       shift    [2];
   logic       sclk     [2];
   logic       cs_n     [2];
   logic       miso     [2];
   logic [7:0] rx_data  [2];
   logic       rx_valid [2];
   logic       busy     [2];

   bit         loopback  [2];
   logic [7:0] slave_pat [2];
   logic [7:0] mosi_sh   [2];
   logic [7:0] slave_sh  [2];
   logic       sclk_prev [2];
   logic       csn_prev  [2];

   logic [7:0] exp_q[$];
   int         n_checks;
   int         n_fail;

   always #5 clk = ~clk;

   spi_master_ctrl #(.CLK_DIV(4)) dut_div4 (
      .clk(clk), .reset(reset), .i_tx_valid(tx_valid[0]), .i_tx_byte(tx_byte[0]),
      .o_tx_ready(tx_ready[0]), .o_load(load[0]), .o_shift(shift[0]), .o_sclk(sclk[0]),
      .o_cs_n(cs_n[0]), .i_miso(miso[0]), .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]),
      .o_busy(busy[0])
   );

   spi_master_ctrl #(.CLK_DIV(2)) dut_div2 (
      .clk(clk), .reset(reset), .i_tx_valid(tx_valid[1]), .i_tx_byte(tx_byte[1]),
      .o_tx_ready(tx_ready[1]), .o_load(load[1]), .o_shift(shift[1]), .o_sclk(sclk[1]),
      .o_cs_n(cs_n[1]), .i_miso(miso[1]), .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]),
      .o_busy(busy[1])
   );

   // Downstream shifter (MOSI = msb) and an independent slave that presents its first
   // bit once CS falls and advances after every SCLK falling edge.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         sclk_prev[u] <= sclk[u];
         csn_prev[u]  <= cs_n[u];
         if (load[u]) mosi_sh[u] <= tx_byte[u];
         else if (shift[u]) mosi_sh[u] <= {mosi_sh[u][6:0], 1'b0};
         if (csn_prev[u] && !cs_n[u]) slave_sh[u] <= slave_pat[u];
         else if (sclk_prev[u] && !sclk[u]) slave_sh[u] <= {slave_sh[u][6:0], 1'b0};
      end
   end

   assign miso[0] = loopback[0] ? mosi_sh[0][7] : slave_sh[0][7];
   assign miso[1] = loopback[1] ? mosi_sh[1][7] : slave_sh[1][7];

   function automatic int div_of(input int u);
      return (u == 0) ? 4 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Offer a byte and wait (bounded) for acceptance; returns at the first sample after E0.
   task automatic send(input int u, input logic [7:0] tx, input bit keep,
                       input logic [7:0] next_byte, output int waited);
      waited = 0;
      tx_byte[u]  = tx;
      tx_valid[u] = 1'b1;
      #1;
      while (!tx_ready[u] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("u%0d accept_timeout", u), waited < 200, 1);
      check($sformatf("u%0d load_on_accept", u), load[u], 1);
      @(negedge clk);
      if (keep) tx_byte[u] = next_byte;
      else tx_valid[u] = 1'b0;
   endtask

   // Observe one frame from sample t=0 (just after E0) to t=18*D and compare with the model.
   task automatic monitor_frame(input int u, input logic [7:0] tx);
      int d, cs_rise, gap_n, busy_bad, csl_bad, load_bad, ready_bad;
      int rises[$], falls[$], shifts[$], rxv_t[$];
      logic ps, pc;
      logic [7:0] got_rx, mosi_bits, exp_rx;
      d = div_of(u);
      cs_rise = -1; gap_n = 0; busy_bad = 0; csl_bad = 0; load_bad = 0; ready_bad = 0;
      ps = 1'b0; pc = 1'b0; got_rx = 8'h00; mosi_bits = 8'h00;
      for (int t = 0; t <= 18 * d; t++) begin
         if (sclk[u] && !ps) begin
            if (rises.size() < 8) mosi_bits[7 - rises.size()] = mosi_sh[u][7];
            rises.push_back(t);
         end
         if (!sclk[u] && ps) falls.push_back(t);
         if (shift[u]) shifts.push_back(t);
         if (cs_n[u] && !pc && cs_rise < 0) cs_rise = t;
         if (t < 17 * d && cs_n[u]) csl_bad++;
         if (rx_valid[u]) begin
            rxv_t.push_back(t);
            got_rx = rx_data[u];
         end
         if (t < 18 * d && !busy[u]) busy_bad++;
         if (t < 18 * d && tx_ready[u]) ready_bad++;
         if (t < 18 * d && load[u]) load_bad++;
         if (cs_n[u] && busy[u]) gap_n++;
         ps = sclk[u];
         pc = cs_n[u];
         if (t < 18 * d) @(negedge clk);
      end
      exp_rx = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("u%0d sclk_rise_count", u), rises.size(), 8);
      check($sformatf("u%0d sclk_fall_count", u), falls.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < rises.size()) check($sformatf("u%0d sclk_rise%0d", u, i), rises[i], (2 * i + 1) * d);
         if (i < falls.size()) check($sformatf("u%0d sclk_fall%0d", u, i), falls[i], (2 * i + 2) * d);
      end
      check($sformatf("u%0d shift_count", u), shifts.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < shifts.size()) check($sformatf("u%0d shift%0d", u, i), shifts[i], (2 * i + 2) * d - 1);
      end
      check($sformatf("u%0d mosi_bits", u), mosi_bits, tx);
      check($sformatf("u%0d cs_rise", u), cs_rise, 17 * d);
      check($sformatf("u%0d cs_low_bad", u), csl_bad, 0);
      check($sformatf("u%0d gap_len", u), gap_n, d);
      check($sformatf("u%0d busy_bad", u), busy_bad, 0);
      check($sformatf("u%0d ready_early", u), ready_bad, 0);
      check($sformatf("u%0d load_in_frame", u), load_bad, 0);
      check($sformatf("u%0d rx_valid_count", u), rxv_t.size(), 1);
      if (rxv_t.size() > 0) check($sformatf("u%0d rx_valid_time", u), rxv_t[0], 17 * d);
      check($sformatf("u%0d rx_data_at_valid", u), got_rx, exp_rx);
      check($sformatf("u%0d rx_data_held", u), rx_data[u], exp_rx);
      check($sformatf("u%0d ready_return", u), tx_ready[u], 1);
      check($sformatf("u%0d load_at_return", u), load[u], tx_valid[u]);
   endtask

   task automatic frame(input int u, input logic [7:0] tx, input bit lb, input logic [7:0] spat);
      int w;
      loopback[u]  = lb;
      slave_pat[u] = spat;
      exp_q.push_back(lb ? tx : spat);
      send(u, tx, 1'b0, 8'h00, w);
      monitor_frame(u, tx);
   endtask

   initial begin
      int w;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      for (int u = 0; u < 2; u++) begin
         tx_valid[u]  = 1'b0;
         tx_byte[u]   = 8'h00;
         loopback[u]  = 1'b1;
         slave_pat[u] = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset_outputs", u),
               {cs_n[u], sclk[u], tx_ready[u], busy[u], load[u], shift[u], rx_valid[u]},
               7'b1010000);
         check($sformatf("u%0d reset_rx_data", u), rx_data[u], 8'h00);
      end
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++)
            check($sformatf("u%0d idle_outputs", u),
                  {cs_n[u], sclk[u], tx_ready[u], busy[u], load[u], shift[u], rx_valid[u]},
                  7'b1010000);
      end

      // Loopback and independent-slave frames at CLK_DIV=4.
      frame(0, 8'hA5, 1'b1, 8'h00);
      frame(0, 8'hFF, 1'b0, 8'h3C);

      // Back-to-back: valid held high across the frame boundary.
      loopback[0] = 1'b1;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      send(0, 8'h01, 1'b1, 8'h80, w);
      monitor_frame(0, 8'h01);
      send(0, 8'h80, 1'b0, 8'h00, w);
      check("u0 b2b_no_wait", w, 0);
      monitor_frame(0, 8'h80);

      // Reset in the third HIGH phase aborts the frame without an rx pulse.
      send(0, 8'h96, 1'b0, 8'h00, w);
      repeat (5 * 4 + 1) @(negedge clk);
      check("u0 pre_reset_sclk_high", sclk[0], 1);
      reset       = 1'b1;
      tx_valid[0] = 1'b1;
      tx_byte[0]  = 8'h11;
      @(negedge clk);
      check("u0 rst_outputs",
            {cs_n[0], sclk[0], tx_ready[0], busy[0], load[0], shift[0], rx_valid[0]},
            7'b1010000);
      check("u0 rst_rx_cleared", rx_data[0], 8'h00);
      reset       = 1'b0;
      tx_valid[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("u0 post_rst_no_rxv", rx_valid[0], 0);
         check("u0 post_rst_ready", tx_ready[0], 1);
      end
      frame(0, 8'h5A, 1'b1, 8'h00);

      // CLK_DIV=2 instance.
      frame(1, 8'hC3, 1'b1, 8'h00);

      // Randomized frames on both instances.
      repeat (10) begin
         int u;
         u = $urandom_range(0, 1);
         frame(u, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Frame controller for the SPI master. It drives the byte shifter directly downstream of it: it issues that shifter's load and shift strobes, and generates SCLK and active-low chip select. It also samples MISO into a receive byte. SPI mode 0 only (CPOL=0, CPHA=0), MSB first, one 8-bit frame per CS assertion. Upstream uses a valid/ready handshake for TX bytes and gets a one-cycle valid pulse for RX bytes.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range 2..255; SCLK frequency = f_clk / (2*CLK_DIV).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_tx_valid  input  1  upstream has a TX byte on i_tx_byte
i_tx_byte  input  8  TX byte; only qualifies the handshake, it is not stored here (the shifter loads it)
o_tx_ready  output  1  controller idle and able to accept a byte
o_load  output  1  load strobe to shifter; combinational = i_tx_valid & o_tx_ready & ~reset
o_shift  output  1  shift strobe to shifter, one clk wide
o_sclk  output  1  SPI clock, registered
o_cs_n  output  1  SPI chip select, active low, registered
i_miso  input  1  serial data from slave; already synchronous to clk
o_rx_data  output  8  last received byte, held until next frame completes
o_rx_valid  output  1  one-cycle pulse when o_rx_data updates
o_busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, LEAD, HIGH, LOW, TRAIL, GAP. Counters: div_cnt (0..CLK_DIV-1) and bit_cnt (0..7).
- Every non-IDLE state lasts exactly CLK_DIV cycles. div_cnt resets to 0 on each state entry.
- Reset: state=IDLE, o_sclk=0, o_cs_n=1, o_rx_data=0x00, o_rx_valid=0, rx shift reg=0, counters=0. During reset, o_load=0 and o_shift=0. In the first cycle after reset, o_tx_ready=1.
- o_tx_ready = (state==IDLE), decoded combinationally from state.
- Accept edge E0 (i_tx_valid & o_tx_ready):
  - The shifter loads on E0 via o_load.
  - FSM moves to LEAD; o_cs_n<=0; bit_cnt<=0.
  - i_tx_valid while not ready is ignored. Upstream holds it until accepted.
- LEAD: o_sclk=0. At the end -> HIGH, with o_sclk<=1 and rx_shift<={rx_shift[6:0], i_miso} on the same edge.
- HIGH: o_sclk=1. At the end, o_sclk<=0.
  - If bit_cnt<7: o_shift=1 during the last HIGH cycle, so MOSI advances on the SCLK falling edge. bit_cnt<=bit_cnt+1 and go to LOW.
  - If bit_cnt==7: no o_shift; go to TRAIL.
  - Exactly 7 o_shift pulses per frame.
- LOW: o_sclk=0. At the end -> HIGH, sampling i_miso as in LEAD.
- TRAIL: o_sclk=0, o_cs_n=0. At the end: o_cs_n<=1, o_rx_data<=rx_shift, o_rx_valid<=1 for one cycle, go to GAP.
- GAP: o_cs_n=1, o_sclk=0. Guarantees a minimum CS-high time. At the end -> IDLE.
- Timing, relative to E0:
  - SCLK rises at E0+(2i+1)*CLK_DIV and falls at E0+(2i+2)*CLK_DIV, for i=0..7.
  - o_cs_n rises at E0+17*CLK_DIV.
  - o_rx_valid is high in the cycle after that edge.
  - o_tx_ready returns at E0+18*CLK_DIV.
- Back-to-back frames: ready and valid in the same IDLE cycle give a new E0 immediately. There are no dead cycles beyond GAP.
- Reset mid-frame: next edge forces IDLE, o_cs_n=1, o_sclk=0. No o_rx_valid pulse; o_rx_data cleared to 0.

Test Plan:
- Reset then idle, i_tx_valid=0 for 20 cycles -> o_cs_n=1, o_sclk=0, o_tx_ready=1, o_busy=0, o_load=o_shift=o_rx_valid=0 throughout.
- CLK_DIV=4, send 0xA5, shifter instantiated in bench with MISO looped to MOSI -> 8 SCLK rising edges at E0+4,12,...,60; 7 o_shift pulses; o_cs_n rises at E0+68; o_rx_data=0xA5 with a single o_rx_valid pulse; o_tx_ready at E0+72.
- Slave model drives MISO=0x3C (changing on SCLK falling edges, first bit valid at CS fall) while TX=0xFF -> o_rx_data=0x3C; MOSI stays 1 for the whole frame.
- Back-to-back: i_tx_valid held high with 0x01 then 0x80 -> second o_load in the cycle o_tx_ready returns; CS-high gap exactly CLK_DIV cycles; rx bytes 0x01, 0x80 in loopback.
- Reset asserted in the 3rd HIGH phase -> next cycle o_cs_n=1, o_sclk=0, o_tx_ready=1; no o_rx_valid; a subsequent frame of 0x5A completes correctly.
- CLK_DIV=2 build, send 0xC3 loopback -> SCLK period 4 clk, frame 34 cycles E0 to CS rise, o_rx_data=0xC3.
